pwm_regs_mc: RTL and testbench
==============================

Name: pwm_regs_mc

Overview:
Multi-channel, parametrised register bank for the PWM generator. It replaces the single-channel 16-bit register file.
- Decodes byte-wide read/write accesses from the SPI decoder.
- Holds per-channel counter/PWM configuration.
- Double-buffers PERIOD/COMPARE1/COMPARE2 so updates apply only at counter overflow.
- Generates fixed-length counter-reset pulses and collects per-channel overflow interrupts.

Parameters:
- NCH, 4, channel count, 1..7.
- CW, 16, counter/compare width in bits, one of 8/16/24/32.
- RST_PULSE, 2, count_reset pulse length in clk cycles, 1..15.

Ports:
- clk  in  1  peripheral clock.
- rst_n  in  1  reset: asynchronous, active-low.
- read  in  1  read strobe from decoder.
- write  in  1  write strobe from decoder (single-cycle).
- addr  in  8  addr[7:5] = channel (7 = global block), addr[4:0] = offset.
- data_write  in  8  write byte.
- data_read  out  8  read byte, combinational.
- counter_val  in  NCH*CW  live counter values, channel c at [c*CW +: CW].
- update_evt  in  NCH  one-cycle overflow/underflow pulse per channel from the counters.
- period, compare1, compare2  out  NCH*CW each  active (shadowed) values.
- en, upnotdown, pwm_en, count_reset  out  NCH each.
- prescale  out  NCH*8.
- functions  out  NCH*2.
- irq  out  1  level interrupt.

Behaviour:
- Reset: all staging, active, CTRL, PRESCALE, pending, IRQ_STATUS and IRQ_ENABLE = 0. count_reset = 0, irq = 0, data_read = 0.
- Per-channel offsets. Multi-byte registers are little-endian. Bytes at index >= CW/8 read 0 and ignore writes.
  - 0x00-0x03 PERIOD (RW, staging).
  - 0x04-0x07 COMPARE1 (RW, staging).
  - 0x08-0x0B COMPARE2 (RW, staging).
  - 0x0C-0x0F COUNTER_VAL (RO, from counter_val).
  - 0x10 CTRL (RW): bit0 en, bit1 upnotdown, bit2 pwm_en, bits4:3 functions; bits7:5 read 0.
  - 0x11 PRESCALE (RW).
  - 0x12 COUNTER_RESET (WO, reads 0).
  - 0x13 SHADOW_STATUS (RO): bit0 = pending.
- Global block (addr[7:5]=7):
  - 0x00 IRQ_STATUS: W1C, bit c = channel c.
  - 0x01 IRQ_ENABLE (RW).
  - 0x02 ID (RO) = {1'b0, NCH[2:0], (CW/8)[3:0]}.
- Channel >= NCH (and not 7), or undefined offset: reads 0, writes ignored.
- Reads of PERIOD/COMPARE bytes return staging values, not active values. When read=0, data_read = 0.
- Writes and CTRL/PRESCALE updates take effect on the clk edge of the write cycle, i.e. outputs change the next cycle.
- Shadowing:
  - A write to any PERIOD/COMPARE byte sets pending[c].
  - Staging is copied to the active outputs on the edge where (update_evt[c] | !en[c]) && pending[c]. pending[c] clears on that edge.
  - With en=0 the transfer occurs 1 cycle after the write.
  - Simultaneous write and transfer in the same cycle: active takes the pre-write staging value, the staging byte takes the new data, and pending stays 1.
- COUNTER_RESET:
  - A write loads per-channel pulse counter = RST_PULSE.
  - count_reset[c] is registered and high for exactly RST_PULSE cycles, starting the cycle after the write.
  - A rewrite during a pulse reloads to the full length, extending the pulse. Write data is ignored.
- IRQ:
  - update_evt[c] sets IRQ_STATUS[c] on that edge.
  - A W1C write clears the bits written as 1. Simultaneous set and clear of the same bit: set wins.
  - irq = |(IRQ_STATUS & IRQ_ENABLE), registered, so it asserts 1 cycle after the status bit is set.
- Reset mid-operation: immediate asynchronous clear of all state, including in-flight pulses and pending transfers.

Decomposition:
- Package pwm_regs_pkg holds:
  - offset localparams (OFF_PERIOD, OFF_CMP1, OFF_CMP2, OFF_CVAL, OFF_CTRL, OFF_PRESCALE, OFF_CRST, OFF_SHSTAT, G_IRQ_STAT, G_IRQ_EN, G_ID);
  - GLOBAL_CH = 3'd7;
  - CTRL bit positions.
- Sub-module pwm_regs_ch: one channel's staging/active/pending/CTRL/PRESCALE/pulse counter, plus its read mux. It is instantiated NCH times in a generate loop.
- The top level holds the channel decode, the global block, the IRQ logic and the final read mux.

Test Plan:
1. Reset -> all outputs 0. Read of ID with NCH=4, CW=16 returns 0x42.
2. Ch1: en=0, write PERIOD 0x34 @0x20 and 0x12 @0x21 -> period[1] = 0x1234 one cycle after the second write, and SHADOW_STATUS reads 0.
3. Ch0: en=1, write COMPARE1 = 0x0080 -> compare1[0] unchanged and pending=1. Pulse update_evt[0] -> compare1[0] = 0x0080 next cycle and pending=0.
4. Ch0: write to COMPARE1 in the same cycle as update_evt[0] -> active takes the old staging value, pending stays 1. The next update_evt applies the new value.
5. Write COUNTER_RESET ch2 (0x52) -> count_reset[2] high exactly 2 cycles. A rewrite on pulse cycle 2 extends it to 3 cycles total.
6. IRQ_ENABLE = 0x01, pulse update_evt[0] -> irq = 1. Write 0x01 to IRQ_STATUS while update_evt[0] pulses in the same cycle -> bit stays set. A later W1C alone clears it and irq drops.

Source files
------------

// File: rtl/pwm_regs_pkg.sv
// Shared register map, CTRL bit layout and byte-lane helper for the PWM register bank.
package pwm_regs_pkg;

  localparam logic [4:0] OFF_PERIOD   = 5'h00;
  localparam logic [4:0] OFF_CMP1     = 5'h04;
  localparam logic [4:0] OFF_CMP2     = 5'h08;
  localparam logic [4:0] OFF_CVAL     = 5'h0C;
  localparam logic [4:0] OFF_CTRL     = 5'h10;
  localparam logic [4:0] OFF_PRESCALE = 5'h11;
  localparam logic [4:0] OFF_CRST     = 5'h12;
  localparam logic [4:0] OFF_SHSTAT   = 5'h13;

  localparam logic [4:0] G_IRQ_STAT   = 5'h00;
  localparam logic [4:0] G_IRQ_EN     = 5'h01;
  localparam logic [4:0] G_ID         = 5'h02;

  localparam logic [2:0] GLOBAL_CH    = 3'd7;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_UPDN  = 1;
  localparam int CTRL_PWMEN = 2;
  localparam int CTRL_FN_LO = 3;

  // Index of a shadowed register within the staging/active arrays (offset bits [3:2]).
  typedef enum logic [1:0] {
    SH_PERIOD = 2'd0,
    SH_CMP1   = 2'd1,
    SH_CMP2   = 2'd2
  } shadow_sel_e;

  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] idx,
                                         input int nbytes);
    logic [31:0] sh;
    sh = v >> {idx, 3'b000};
    return (int'(idx) < nbytes) ? sh[7:0] : 8'h00;
  endfunction

endpackage

// File: rtl/pwm_regs_ch.sv
// One PWM channel: staging/active shadow registers, CTRL, PRESCALE, reset-pulse timer, read mux.
// Register writes land on the write-cycle edge; shadow transfer on overflow (or at once when disabled).
module pwm_regs_ch
  import pwm_regs_pkg::*;
#(
  parameter int CW        = 16,
  parameter int RST_PULSE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [4:0]    off,
  input  logic [7:0]    wdata,
  input  logic [CW-1:0] counter,
  input  logic          update_evt,
  output logic [CW-1:0] period,
  output logic [CW-1:0] compare1,
  output logic [CW-1:0] compare2,
  output logic          en,
  output logic          upnotdown,
  output logic          pwm_en,
  output logic          count_reset,
  output logic [7:0]    prescale,
  output logic [1:0]    functions,
  output logic [7:0]    rd_data
);

  localparam int NB = CW / 8;

  logic [CW-1:0] stg [3];
  logic [CW-1:0] act [3];
  logic [4:0]    ctrl;
  logic [7:0]    pre;
  logic          pending;
  logic [3:0]    pcnt;
  logic [3:0]    pcnt_nxt;
  logic          cr;
  logic          shd_wr;
  logic          xfer;
  logic [1:0]    sel;

  assign sel    = off[3:2];
  assign shd_wr = wr && (off < OFF_CVAL) && (int'(off[1:0]) < NB);
  assign xfer   = (update_evt || !ctrl[CTRL_EN]) && pending;

  // Transfer samples the staging value before this edge's write, so a colliding
  // write is kept for the next transfer (pending stays set).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        stg[i] <= '0;
        act[i] <= '0;
      end
      pending <= 1'b0;
    end else begin
      if (xfer) begin
        for (int i = 0; i < 3; i++) act[i] <= stg[i];
      end
      if (shd_wr) begin
        for (int b = 0; b < NB; b++) begin
          if (int'(off[1:0]) == b) stg[sel][b*8 +: 8] <= wdata;
        end
      end
      if (shd_wr)    pending <= 1'b1;
      else if (xfer) pending <= 1'b0;
    end
  end

  always_comb begin
    pcnt_nxt = pcnt;
    if (wr && off == OFF_CRST) pcnt_nxt = 4'(RST_PULSE);
    else if (pcnt != 4'd0)     pcnt_nxt = pcnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
      pre  <= '0;
      pcnt <= '0;
      cr   <= 1'b0;
    end else begin
      if (wr && off == OFF_CTRL)     ctrl <= wdata[4:0];
      if (wr && off == OFF_PRESCALE) pre  <= wdata;
      pcnt <= pcnt_nxt;
      cr   <= (pcnt_nxt != 4'd0);
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (off < OFF_CVAL)      rd_data = byte_of(32'(stg[sel]), off[1:0], NB);
    else if (off < OFF_CTRL) rd_data = byte_of(32'(counter), off[1:0], NB);
    else begin
      case (off)
        OFF_CTRL:     rd_data = {3'b000, ctrl};
        OFF_PRESCALE: rd_data = pre;
        OFF_SHSTAT:   rd_data = {7'b0, pending};
        default:      rd_data = 8'h00;
      endcase
    end
  end

  assign period      = act[SH_PERIOD];
  assign compare1    = act[SH_CMP1];
  assign compare2    = act[SH_CMP2];
  assign en          = ctrl[CTRL_EN];
  assign upnotdown   = ctrl[CTRL_UPDN];
  assign pwm_en      = ctrl[CTRL_PWMEN];
  assign functions   = ctrl[CTRL_FN_LO +: 2];
  assign prescale    = pre;
  assign count_reset = cr;

endmodule

// File: rtl/pwm_regs_mc.sv
// Multi-channel PWM register bank: channel decode, global IRQ block, final read mux.
// Reads are combinational; writes land on the write-cycle edge; irq lags status by one cycle.
module pwm_regs_mc
  import pwm_regs_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CW        = 16,
  parameter int RST_PULSE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [7:0]        addr,
  input  logic [7:0]        data_write,
  output logic [7:0]        data_read,
  input  logic [NCH*CW-1:0] counter_val,
  input  logic [NCH-1:0]    update_evt,
  output logic [NCH*CW-1:0] period,
  output logic [NCH*CW-1:0] compare1,
  output logic [NCH*CW-1:0] compare2,
  output logic [NCH-1:0]    en,
  output logic [NCH-1:0]    upnotdown,
  output logic [NCH-1:0]    pwm_en,
  output logic [NCH-1:0]    count_reset,
  output logic [NCH*8-1:0]  prescale,
  output logic [NCH*2-1:0]  functions,
  output logic              irq
);

  logic [2:0]     ch;
  logic [4:0]     off;
  logic [7:0]     ch_rd [NCH];
  logic           gwr;
  logic [NCH-1:0] irq_stat;
  logic [NCH-1:0] irq_en;
  logic [NCH-1:0] irq_clr;
  logic [7:0]     glob_rd;
  logic [7:0]     id;

  assign ch  = addr[7:5];
  assign off = addr[4:0];
  assign id  = {1'b0, 3'(NCH), 4'(CW / 8)};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pwm_regs_ch #(.CW(CW), .RST_PULSE(RST_PULSE)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (write && ch == 3'(c)),
      .off        (off),
      .wdata      (data_write),
      .counter    (counter_val[c*CW +: CW]),
      .update_evt (update_evt[c]),
      .period     (period[c*CW +: CW]),
      .compare1   (compare1[c*CW +: CW]),
      .compare2   (compare2[c*CW +: CW]),
      .en         (en[c]),
      .upnotdown  (upnotdown[c]),
      .pwm_en     (pwm_en[c]),
      .count_reset(count_reset[c]),
      .prescale   (prescale[c*8 +: 8]),
      .functions  (functions[c*2 +: 2]),
      .rd_data    (ch_rd[c])
    );
  end

  assign gwr     = write && ch == GLOBAL_CH;
  assign irq_clr = (gwr && off == G_IRQ_STAT) ? data_write[NCH-1:0] : '0;

  // Set is OR-ed in after the clear so a coincident overflow is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_stat <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~irq_clr) | update_evt;
      if (gwr && off == G_IRQ_EN) irq_en <= data_write[NCH-1:0];
      irq <= |(irq_stat & irq_en);
    end
  end

  always_comb begin
    case (off)
      G_IRQ_STAT: glob_rd = 8'(irq_stat);
      G_IRQ_EN:   glob_rd = 8'(irq_en);
      G_ID:       glob_rd = id;
      default:    glob_rd = 8'h00;
    endcase
  end

  always_comb begin
    data_read = 8'h00;
    if (read) begin
      if (ch == GLOBAL_CH) data_read = glob_rd;
      else begin
        for (int c = 0; c < NCH; c++) begin
          if (ch == 3'(c)) data_read = ch_rd[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Directed bench for pwm_regs_mc (NCH=4, CW=16, RST_PULSE=2) with hand-computed expectations.
module tb_pwm_regs_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read;
  logic        write;
  logic [7:0]  addr;
  logic [7:0]  data_write;
  logic [7:0]  data_read;
  logic [63:0] counter_val;
  logic [3:0]  update_evt;
  logic [63:0] period, compare1, compare2;
  logic [3:0]  en, upnotdown, pwm_en, count_reset;
  logic [31:0] prescale;
  logic [7:0]  functions;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  pwm_regs_mc #(.NCH(4), .CW(16), .RST_PULSE(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_write (data_write),
    .data_read  (data_read),
    .counter_val(counter_val),
    .update_evt (update_evt),
    .period     (period),
    .compare1   (compare1),
    .compare2   (compare2),
    .en         (en),
    .upnotdown  (upnotdown),
    .pwm_en     (pwm_en),
    .count_reset(count_reset),
    .prescale   (prescale),
    .functions  (functions),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    write      = 1'b1;
    addr       = a;
    data_write = d;
    tick();
    write      = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    read = 1'b1;
    addr = a;
    #1;
    check(tag, 64'(data_read), 64'(exp));
    read = 1'b0;
    #1;
  endtask

  initial begin
    int highs;
    rst_n       = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    addr        = 8'h00;
    data_write  = 8'h00;
    counter_val = 64'h0;
    update_evt  = 4'h0;
    #1;
    check("rst_period", period, 64'h0);
    check("rst_cmp1", compare1, 64'h0);
    check("rst_crst", 64'(count_reset), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_dread", 64'(data_read), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    rd_chk("id", 8'hE2, 8'h42);
    rd_chk("undef_ch5", 8'hA0, 8'h00);
    rd_chk("undef_off", 8'h14, 8'h00);

    // Ch1 disabled: each write transfers one cycle later
    wr(8'h20, 8'h34);
    wr(8'h21, 8'h12);
    check("per1_mid", 64'(period[31:16]), 64'h0034);
    rd_chk("per1_stg_hi", 8'h21, 8'h12);
    rd_chk("per1_byte2", 8'h22, 8'h00);
    tick();
    check("per1_final", 64'(period[31:16]), 64'h1234);
    rd_chk("per1_shstat", 8'h33, 8'h00);

    // Ch0 enabled: hold until overflow
    wr(8'h10, 8'h01);
    check("en0", 64'(en), 64'h1);
    wr(8'h04, 8'h80);
    wr(8'h05, 8'h00);
    check("cmp1_hold", 64'(compare1[15:0]), 64'h0);
    rd_chk("cmp1_pend", 8'h13, 8'h01);
    update_evt = 4'b0001;
    tick();
    update_evt = 4'b0000;
    check("cmp1_apply", 64'(compare1[15:0]), 64'h0080);
    rd_chk("cmp1_clr", 8'h13, 8'h00);

    // Collision of write and transfer
    wr(8'h04, 8'h11);
    update_evt = 4'b0001;
    wr(8'h04, 8'h22);
    update_evt = 4'b0000;
    check("coll_act", 64'(compare1[15:0]), 64'h0011);
    rd_chk("coll_pend", 8'h13, 8'h01);
    rd_chk("coll_stg", 8'h04, 8'h22);
    update_evt = 4'b0001;
    tick();
    update_evt = 4'b0000;
    check("coll_next", 64'(compare1[15:0]), 64'h0022);

    // CTRL, PRESCALE, COUNTER_VAL on ch3/ch0
    wr(8'h70, 8'hFE);
    check("fn3", 64'(functions[7:6]), 64'h3);
    check("pwmen3", 64'(pwm_en), 64'h8);
    check("updn3", 64'(upnotdown), 64'h8);
    rd_chk("ctrl3_rd", 8'h70, 8'h1E);
    wr(8'h71, 8'h5A);
    check("pre3", 64'(prescale[31:24]), 64'h5A);
    counter_val[15:0] = 16'hBEEF;
    rd_chk("cval_lo", 8'h0C, 8'hEF);
    rd_chk("cval_hi", 8'h0D, 8'hBE);
    rd_chk("cval_b2", 8'h0E, 8'h00);
    rd_chk("crst_rd", 8'h12, 8'h00);

    // Counter reset pulse on ch2
    wr(8'h52, 8'hAA);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (count_reset[2]) highs++;
      tick();
    end
    check("crst_len", 64'(highs), 64'd2);
    wr(8'h52, 8'h00);
    highs = count_reset[2] ? 1 : 0;
    wr(8'h52, 8'h00);
    for (int i = 0; i < 6; i++) begin
      if (count_reset[2]) highs++;
      tick();
    end
    check("crst_ext", 64'(highs), 64'd3);
    check("crst_others", 64'(count_reset), 64'h0);

    // IRQ status/enable
    rd_chk("irq_stat_prev", 8'hE0, 8'h01);
    wr(8'hE0, 8'h0F);
    rd_chk("irq_stat_clr0", 8'hE0, 8'h00);
    wr(8'hE1, 8'h01);
    rd_chk("irq_en_rd", 8'hE1, 8'h01);
    update_evt = 4'b0001;
    tick();
    update_evt = 4'b0000;
    rd_chk("irq_stat_set", 8'hE0, 8'h01);
    check("irq_lag", 64'(irq), 64'h0);
    tick();
    check("irq_on", 64'(irq), 64'h1);
    update_evt = 4'b0001;
    wr(8'hE0, 8'h01);
    update_evt = 4'b0000;
    rd_chk("irq_setwins", 8'hE0, 8'h01);
    check("irq_hold", 64'(irq), 64'h1);
    wr(8'hE0, 8'h01);
    rd_chk("irq_w1c", 8'hE0, 8'h00);
    tick();
    check("irq_off", 64'(irq), 64'h0);

    // Asynchronous reset mid-pulse
    wr(8'h52, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_crst", 64'(count_reset), 64'h0);
    check("arst_period", period, 64'h0);
    check("arst_en", 64'(en), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
